// File: rtl/eth_rx_packer_if.sv
// eth_rx_packer_if: MAC receive byte stream plus the core-facing FIFO pop port.
// master = MAC/core side (drives bytes and pops), slave = the packer.
interface eth_rx_packer_if;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_last;
    logic          rx_err;
    logic [1047:0] ethernet_rx;
    logic          rxfifoemp;
    logic          ethernet_rx_re;

    modport master (
        output rx_data, rx_valid, rx_last, rx_err, ethernet_rx_re,
        input  ethernet_rx, rxfifoemp
    );

    modport slave (
        input  rx_data, rx_valid, rx_last, rx_err, ethernet_rx_re,
        output ethernet_rx, rxfifoemp
    );
endinterface

// File: rtl/eth_rx_packer.sv
// eth_rx_packer: packs MAC receive bytes into 1048-bit tagged segment words
// and buffers them in a first-word-fall-through FIFO for the core.
// Word: [1047:1032] byte count, [1031:1024] flags {ERR,EOF,SOF}, [1023:0] payload.
// Frames that find the FIFO full are dropped; the MAC is never stalled.
// Optional macro ETH_RX_STATS_EN adds the drop/frame counters (else they read 0).
//
// state   | meaning
// --------+-------------------------------------------------------------
// SYNC    | after reset, discard bytes until one idle cycle is seen
// IDLE    | waiting for the first byte of a frame
// FILL    | packing bytes of a frame into the current segment
// DROP    | frame lost to a full FIFO, discard until its last byte
module eth_rx_packer #(
    parameter int DEPTH     = 4,
    parameter int SEG_BYTES = 128
) (
    input  logic              inclk,
    input  logic              inrst,
    eth_rx_packer_if.slave    bus,
    output logic              rx_overflow,
    output logic [15:0]       drop_cnt,
    output logic [31:0]       frame_cnt
);
    localparam int AW     = $clog2(DEPTH);
    localparam int IW     = $clog2(SEG_BYTES);
    localparam int PW     = 8 * SEG_BYTES;
    localparam int WORD_W = 24 + PW;

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]        state;
    logic [PW-1:0]     payload;
    logic [PW-1:0]     nxt_payload;
    logic [IW-1:0]     idx;
    logic              sof;
    logic              accept;
    logic              seg_full;
    logic              commit;
    logic              fifo_full;
    logic              push;
    logic              drop;
    logic              pop;
    logic [WORD_W-1:0] word;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    // Commit decision and the segment word as it would look with this byte included.
    always_comb begin
        accept    = bus.rx_valid && (state == ST_IDLE || state == ST_FILL);
        seg_full  = (idx == IW'(SEG_BYTES - 1));
        commit    = accept && (bus.rx_last || seg_full);
        // A same-cycle pop does not make room: fullness is judged before the edge.
        fifo_full = (count == (AW + 1)'(DEPTH));
        push      = commit && !fifo_full;
        drop      = commit && fifo_full;
        pop       = bus.ethernet_rx_re && (count != '0);
        nxt_payload = payload;
        nxt_payload[{idx, 3'b000} +: 8] = bus.rx_data;
        word = {16'(idx) + 16'd1, 5'b00000, bus.rx_err & bus.rx_last,
                bus.rx_last, sof, nxt_payload};
    end

    // Frame FSM and assembly buffer; the buffer clears on commit so the next byte lands at index 0.
    always_ff @(posedge inclk or negedge inrst) begin
        if (!inrst) begin
            state       <= ST_SYNC;
            payload     <= '0;
            idx         <= '0;
            sof         <= 1'b1;
            rx_overflow <= 1'b0;
        end else begin
            rx_overflow <= drop;
            case (state)
                ST_SYNC: begin
                    if (!bus.rx_valid) state <= ST_IDLE;
                end
                ST_IDLE, ST_FILL: begin
                    if (bus.rx_valid) begin
                        if (commit) begin
                            payload <= '0;
                            idx     <= '0;
                            if (bus.rx_last) begin
                                state <= ST_IDLE;
                                sof   <= 1'b1;
                            end else if (fifo_full) begin
                                state <= ST_DROP;
                                sof   <= 1'b1;
                            end else begin
                                state <= ST_FILL;
                                sof   <= 1'b0;
                            end
                        end else begin
                            payload <= nxt_payload;
                            idx     <= idx + IW'(1);
                            state   <= ST_FILL;
                        end
                    end
                end
                ST_DROP: begin
                    if (bus.rx_valid && bus.rx_last) state <= ST_IDLE;
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

    // FIFO storage; contents need no reset because the output is gated by empty.
    always_ff @(posedge inclk) begin
        if (push) mem[wr_ptr] <= word;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge inclk or negedge inrst) begin
        if (!inrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW + 1)'(1);
            else if (pop && !push) count <= count - (AW + 1)'(1);
        end
    end

    assign bus.rxfifoemp   = (count == '0);
    assign bus.ethernet_rx = (count == '0) ? '0 : mem[rd_ptr];

`ifdef ETH_RX_STATS_EN
    // Saturating drop and committed-EOF counters.
    always_ff @(posedge inclk or negedge inrst) begin
        if (!inrst) begin
            drop_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            if (drop && drop_cnt != '1)                    drop_cnt  <= drop_cnt + 16'd1;
            if (push && bus.rx_last && frame_cnt != '1)    frame_cnt <= frame_cnt + 32'd1;
        end
    end
`else
    assign drop_cnt  = '0;
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_rx_packer.sv
// tb_eth_rx_packer: scoreboard bench for eth_rx_packer. Expected words are
// queued as frames are driven and compared when the bench pops them.
module tb_eth_rx_packer;
    localparam int DEPTH = 4;

    logic        inclk = 1'b0;
    logic        inrst;
    logic        rx_overflow;
    logic [15:0] drop_cnt;
    logic [31:0] frame_cnt;

    eth_rx_packer_if bus ();

    eth_rx_packer #(.DEPTH(DEPTH), .SEG_BYTES(128)) dut (
        .inclk       (inclk),
        .inrst       (inrst),
        .bus         (bus),
        .rx_overflow (rx_overflow),
        .drop_cnt    (drop_cnt),
        .frame_cnt   (frame_cnt)
    );

    always #5 inclk = ~inclk;

    int            n_checks  = 0;
    int            n_fail    = 0;
    logic [1047:0] sb [$];
    int            model_cnt = 0;
    bit            exp_ovf   = 1'b0;
    int            exp_drop  = 0;
    int            exp_frame = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [1047:0] obs, input logic [1047:0] exp);
        check_eq({tag, ".hdr"}, 256'(obs[1047:1024]), 256'(exp[1047:1024]));
        for (int q = 0; q < 4; q++)
            check_eq($sformatf("%s.pl%0d", tag, q), obs[q*256 +: 256], exp[q*256 +: 256]);
    endtask

    task automatic check_stats();
`ifdef ETH_RX_STATS_EN
        check_eq("drop_cnt", 256'(drop_cnt), 256'(exp_drop));
        check_eq("frame_cnt", 256'(frame_cnt), 256'(exp_frame));
`else
        check_eq("drop_cnt", 256'(drop_cnt), 256'(0));
        check_eq("frame_cnt", 256'(frame_cnt), 256'(0));
`endif
    endtask

    // One clock: called at a negedge, drives inputs, checks outputs, updates model.
    task automatic drive_cycle(input bit v, input logic [7:0] d, input bit l, input bit e,
                               input bit re, input bit commit, input logic [1047:0] w,
                               output bit dropped);
        logic [1047:0] head;
        bus.rx_valid       = v;
        bus.rx_data        = d;
        bus.rx_last        = l;
        bus.rx_err         = e;
        bus.ethernet_rx_re = re;
        check_eq("rxfifoemp", 256'(bus.rxfifoemp), 256'(model_cnt == 0));
        check_eq("rx_overflow", 256'(rx_overflow), 256'(exp_ovf));
        dropped = 1'b0;
        exp_ovf = 1'b0;
        if (commit && model_cnt == DEPTH) begin
            dropped = 1'b1;
            exp_ovf = 1'b1;
            exp_drop++;
        end
        if (re && model_cnt != 0) begin
            head = sb.pop_front();
            check_word("pop", bus.ethernet_rx, head);
            model_cnt--;
        end
        if (commit && !dropped) begin
            sb.push_back(w);
            model_cnt++;
            if (w[1025]) exp_frame++;
        end
        @(posedge inclk);
        @(negedge inclk);
    endtask

    task automatic send_frame(input int n, input int start, input bit err, input bit pop_last);
        logic [1023:0] pl = '0;
        logic [1047:0] w;
        int  pos = 0;
        bit  sof = 1'b1;
        bit  dropping = 1'b0;
        bit  dr;
        bit  last;
        bit  e;
        bit  commit;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d    = 8'(start + i);
            last = (i == n - 1);
            e    = err && last;
            if (dropping) begin
                drive_cycle(1'b1, d, last, e, 1'b0, 1'b0, '0, dr);
                continue;
            end
            pl[pos*8 +: 8] = d;
            commit = last || (pos == 127);
            w = {16'(pos + 1), 5'b00000, e, last, sof, pl};
            drive_cycle(1'b1, d, last, e, pop_last && last, commit, w, dr);
            if (commit) begin
                pl  = '0;
                pos = 0;
                sof = 1'b0;
                if (dr && !last) dropping = 1'b1;
            end else begin
                pos++;
            end
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, dr);
    endtask

    task automatic pop_n(input int k);
        bit dr;
        for (int i = 0; i < k; i++)
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, '0, dr);
    endtask

    task automatic idle_n(input int k);
        bit dr;
        for (int i = 0; i < k; i++)
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, dr);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ".emp"}, 256'(bus.rxfifoemp), 256'(1));
        check_word({tag, ".word"}, bus.ethernet_rx, '0);
        check_eq({tag, ".ovf"}, 256'(rx_overflow), 256'(0));
        check_eq({tag, ".drop"}, 256'(drop_cnt), 256'(0));
        check_eq({tag, ".frame"}, 256'(frame_cnt), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit dr;
        bus.rx_valid       = 1'b0;
        bus.rx_data        = 8'h00;
        bus.rx_last        = 1'b0;
        bus.rx_err         = 1'b0;
        bus.ethernet_rx_re = 1'b0;
        inrst = 1'b0;
        repeat (3) @(negedge inclk);
        check_reset_state("reset");
        inrst = 1'b1;
        idle_n(2);

        // 60-byte frame
        send_frame(60, 0, 1'b0, 1'b0);
        check_eq("t1.hdr", 256'(bus.ethernet_rx[1047:1024]), 256'(24'h003C03));
        check_eq("t1.b59", 256'(bus.ethernet_rx[479:472]), 256'(8'h3B));
        check_stats();
        pop_n(1);

        // 300-byte frame, three segments
        send_frame(300, 0, 1'b0, 1'b0);
        check_stats();
        pop_n(3);

        // 1-byte errored frame
        send_frame(1, 8'hA5, 1'b1, 1'b0);
        check_eq("t3.hdr", 256'(bus.ethernet_rx[1047:1024]), 256'(24'h000107));
        check_eq("t3.b0", 256'(bus.ethernet_rx[7:0]), 256'(8'hA5));
        pop_n(1);

        // Five frames into a 4-deep FIFO, then drain plus one extra pop
        for (int k = 0; k < 5; k++) send_frame(10, 16 * k, 1'b0, 1'b0);
        check_stats();
        pop_n(4);
        pop_n(1);
        check_stats();

        // FIFO full: pop and commit in the same cycle, commit still dropped
        for (int k = 0; k < 4; k++) send_frame(10, 8'h60 + 16 * k, 1'b0, 1'b0);
        send_frame(10, 8'hC0, 1'b0, 1'b1);
        check_stats();
        pop_n(3);
        pop_n(1);

        // Async reset mid-frame with the MAC still sending
        for (int i = 0; i <= 50; i++)
            drive_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, '0, dr);
        inrst = 1'b0;
        sb.delete();
        model_cnt = 0;
        exp_ovf   = 1'b0;
        exp_drop  = 0;
        exp_frame = 0;
        #1;
        check_reset_state("midrst");
        @(negedge inclk);
        for (int i = 51; i < 60; i++)
            drive_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, '0, dr);
        inrst = 1'b1;
        for (int i = 60; i < 100; i++)
            drive_cycle(1'b1, 8'(i), i == 99, 1'b0, 1'b0, 1'b0, '0, dr);
        idle_n(1);
        send_frame(20, 8'h40, 1'b0, 1'b0);
        check_eq("t6.hdr", 256'(bus.ethernet_rx[1047:1024]), 256'(24'h001403));
        pop_n(1);
        check_stats();
        idle_n(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
